// File: rtl/pulse_monitor.sv
// Receiver for a one-hot pulse bus: measures index, width and preceding gap
// of each pulse and queues one record per pulse in a first-word-fall-through FIFO.
module pulse_monitor #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_width,
    output logic [CNT_W-1:0] out_gap,
    output logic             out_err,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        HIGH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] code;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_lat;
    logic [CNT_W-1:0] width_cnt;
    logic             err;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;

    logic [IDX_W-1:0] mem_idx   [DEPTH];
    logic [CNT_W-1:0] mem_width [DEPTH];
    logic [CNT_W-1:0] mem_gap   [DEPTH];
    logic             mem_err   [DEPTH];

    function automatic logic [IDX_W-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= '0;
        else     din_q <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code      <= '0;
            gap_cnt   <= '0;
            gap_lat   <= '0;
            width_cnt <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (din_q == '0) begin
                        gap_cnt <= sat_inc(gap_cnt);
                    end else begin
                        code      <= din_q;
                        width_cnt <= CNT_W'(1);
                        err       <= !$onehot(din_q);
                        gap_lat   <= gap_cnt;
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    if (din_q == '0) begin
                        // the cycle that ends the pulse is already the first gap cycle
                        gap_cnt <= CNT_W'(1);
                        state   <= IDLE;
                    end else begin
                        width_cnt <= sat_inc(width_cnt);
                        if (din_q != code) err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == FULL_CNT);
    assign push    = (state == HIGH) && (din_q == '0);
    assign pop     = !empty && out_ready;
    // a full FIFO still accepts the record when the head leaves on the same edge
    assign wr_en   = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)          wr_ptr   <= wr_ptr + (AW+1)'(1);
            if (pop)            rd_ptr   <= rd_ptr + (AW+1)'(1);
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_idx[wr_addr]   <= lowest_bit(code);
            mem_width[wr_addr] <= width_cnt;
            mem_gap[wr_addr]   <= gap_lat;
            mem_err[wr_addr]   <= err;
        end
    end

    assign out_valid = !empty;
    assign out_idx   = out_valid ? mem_idx[rd_addr]   : '0;
    assign out_width = out_valid ? mem_width[rd_addr] : '0;
    assign out_gap   = out_valid ? mem_gap[rd_addr]   : '0;
    assign out_err   = out_valid ? mem_err[rd_addr]   : 1'b0;

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: directed and random pulses checked against a
// history-based reference model and a record queue.
module tb_pulse_monitor;

    localparam int WIDTH = 10;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int SAT   = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] out_width;
    logic [CNT_W-1:0] out_gap;
    logic             out_err;
    logic             overflow;

    pulse_monitor #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_width(out_width), .out_gap(out_gap),
        .out_err(out_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int width;
        int gap;
        bit err;
    } rec_t;

    // hist holds the bus as the monitor sees it after registering: one
    // leading zero for the reset value, then one entry per clock edge.
    logic [WIDTH-1:0] hist[$];
    rec_t             mq[$];
    bit               m_ovf;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int min_sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Build the record of the pulse that just ended at hist[size-2].
    function automatic rec_t measure();
        rec_t r;
        int   e, s, k, g;
        e = hist.size() - 2;
        s = e;
        while (s > 0 && hist[s-1] != '0) s--;
        r.width = min_sat(e - s + 1);
        r.idx = 0;
        for (int i = WIDTH - 1; i >= 0; i--) if (hist[s][i]) r.idx = i;
        r.err = !$onehot(hist[s]);
        for (int i = s; i <= e; i++) if (hist[i] != hist[s]) r.err = 1'b1;
        g = 0;
        k = s - 1;
        while (k >= 0 && hist[k] == '0) begin
            g++;
            k--;
        end
        r.gap = min_sat(g);
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            chk({tag, ".idx"}, 32'(out_idx), mq[0].idx);
            chk({tag, ".width"}, 32'(out_width), mq[0].width);
            chk({tag, ".gap"}, 32'(out_gap), mq[0].gap);
            chk({tag, ".err"}, 32'(out_err), 32'(mq[0].err));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic [WIDTH-1:0] d, input bit rdy, input string tag);
        bit   ended, do_pop;
        rec_t r;
        din = d;
        out_ready = rdy;
        @(posedge clk);
        ended = (hist[$] == '0) && (hist.size() >= 2) && (hist[hist.size()-2] != '0);
        if (ended) r = measure();
        do_pop = rdy && (mq.size() > 0);
        if (do_pop) void'(mq.pop_front());
        if (ended) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else m_ovf = 1'b1;
        end
        hist.push_back(d);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic ticks(input logic [WIDTH-1:0] d, input int n, input bit rdy, input string tag);
        for (int i = 0; i < n; i++) tick(d, rdy, tag);
    endtask

    // Asserted at a falling edge, released at a later falling edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        din = '0;
        out_ready = 1'b0;
        #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
        chk({tag, ".idx0"}, 32'(out_idx), 32'd0);
        chk({tag, ".width0"}, 32'(out_width), 32'd0);
        chk({tag, ".gap0"}, 32'(out_gap), 32'd0);
        chk({tag, ".err0"}, 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        hist.push_back('0);
        mq.delete();
        m_ovf = 1'b0;
    endtask

    logic [WIDTH-1:0] c1, c2;
    int               w, z, kind, b2;

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // single pulse on bit 3 after five zero cycles counted from release
        ticks('0, 4, 1'b0, "t1z");
        ticks(10'b0000001000, 3, 1'b0, "t1p");
        tick('0, 1'b0, "t1f");
        chk("t1.lat1", 32'(out_valid), 32'd0);
        tick('0, 1'b0, "t1g");
        chk("t1.lat2", 32'(out_valid), 32'd1);
        chk("t1.idx", 32'(out_idx), 32'd3);
        chk("t1.width", 32'(out_width), 32'd3);
        chk("t1.gap", 32'(out_gap), 32'd5);
        chk("t1.err", 32'(out_err), 32'd0);
        tick('0, 1'b1, "t1d");

        // back-to-back pulses with the consumer always ready
        tick(10'b1000000000, 1'b1, "t2a");
        ticks('0, 2, 1'b1, "t2z");
        ticks(10'b0000000001, 4, 1'b1, "t2b");
        ticks('0, 4, 1'b1, "t2e");

        // two bits set
        ticks(10'b0000000110, 2, 1'b0, "t3p");
        ticks('0, 2, 1'b0, "t3z");
        chk("t3.idx", 32'(out_idx), 32'd1);
        chk("t3.width", 32'(out_width), 32'd2);
        chk("t3.err", 32'(out_err), 32'd1);
        tick('0, 1'b1, "t3d");

        // pattern change mid-pulse
        ticks(10'b0000000100, 2, 1'b0, "t4a");
        ticks(10'b0000100000, 2, 1'b0, "t4b");
        ticks('0, 2, 1'b0, "t4z");
        chk("t4.idx", 32'(out_idx), 32'd2);
        chk("t4.width", 32'(out_width), 32'd4);
        chk("t4.err", 32'(out_err), 32'd1);
        tick('0, 1'b1, "t4d");
        ticks('0, 2, 1'b1, "t4e");

        // width saturation, then a fifth record is dropped
        ticks(10'b0010000000, 300, 1'b0, "t5w");
        ticks('0, 2, 1'b0, "t5z");
        for (int p = 0; p < 4; p++) begin
            tick(10'b0000000001 << p, 1'b0, "t5p");
            ticks('0, 2, 1'b0, "t5g");
        end
        ticks('0, 2, 1'b0, "t5e");
        chk("t5.ovf", 32'(overflow), 32'd1);
        chk("t5.sat", 32'(out_width), 32'd255);
        ticks('0, 6, 1'b1, "t5d");
        chk("t5.ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-pulse with records queued
        ticks(10'b0000010000, 2, 1'b0, "t6a");
        ticks('0, 2, 1'b0, "t6z");
        ticks(10'b0001000000, 2, 1'b0, "t6b");
        ticks('0, 2, 1'b0, "t6y");
        ticks(10'b0100000000, 2, 1'b0, "t6c");
        do_reset("t6rst");
        ticks('0, 3, 1'b0, "t6r");
        ticks(10'b0000010000, 2, 1'b0, "t6p");
        ticks('0, 2, 1'b0, "t6f");
        chk("t6.valid", 32'(out_valid), 32'd1);
        chk("t6.gap", 32'(out_gap), 32'd4);
        chk("t6.width", 32'(out_width), 32'd2);
        ticks('0, 2, 1'b1, "t6d");

        // randomized pulses, patterns and consumer readiness
        for (int p = 0; p < 150; p++) begin
            z = $urandom_range(0, 5);
            w = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            c1 = 10'b0000000001 << $urandom_range(0, WIDTH - 1);
            c2 = 10'b0000000001 << $urandom_range(0, WIDTH - 1);
            if (kind == 0) c1 = c1 | c2;
            for (int i = 0; i < z; i++) tick('0, ($urandom_range(0, 3) != 0), "rz");
            for (int i = 0; i < w; i++) begin
                b2 = (kind == 1 && i >= w / 2) ? 1 : 0;
                tick(b2 != 0 ? c2 : c1, ($urandom_range(0, 3) != 0), "rp");
            end
        end
        ticks('0, 8, 1'b1, "rend");
        chk("rend.empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
